// File: rtl/eth_pkg.sv
// Shared Ethernet CRC-32 definitions: reflected polynomial, init/residual constants,
// a one-byte combinational CRC step and the FCS generator state type.
package eth_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESID     = 32'h2144_DF1C;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAD  = 2'd2,
      FCS  = 2'd3
   } fcs_state_e;

   // LSB-first byte update; unrolled by synthesis into a single XOR network.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h00_0000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32_stream_gen.sv
// TX FCS generator: passes the frame through, zero-pads to MIN_LEN bytes and
// appends the 4-byte FCS (complemented CRC, least significant byte first).
module eth_crc32_stream_gen
   import eth_pkg::*;
#(
   parameter int MIN_LEN = 60,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_done
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

   fcs_state_e       state;
   logic [31:0]      crc;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       fcs_idx;
   logic             run;

   logic             adv;
   logic             take;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_next;
   logic [31:0]      fcs;

   // Handshake: a byte moves on either side only in a cycle where valid and ready
   // are both high; once raised, out_valid/out_data/out_last hold until out_ready.
   assign adv        = !out_valid || out_ready;
   assign in_ready   = run && adv && (state == IDLE || state == DATA);
   assign take       = in_valid && in_ready;
   assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign cnt_next   = (state == IDLE) ? CNT_W'(1) : cnt_inc;
   assign fcs        = ~crc;
   assign frame_done = out_valid && out_ready && out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         crc       <= CRC32_INIT;
         cnt       <= '0;
         fcs_idx   <= 2'd0;
         run       <= 1'b0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         // run keeps in_ready low until the first cycle after reset release
         run <= 1'b1;
         if (adv) begin
            out_last <= 1'b0;
            case (state)
               IDLE, DATA: begin
                  if (take) begin
                     out_data  <= in_data;
                     out_valid <= 1'b1;
                     crc       <= crc32_byte(crc, in_data);
                     cnt       <= cnt_next;
                     fcs_idx   <= 2'd0;
                     if (in_last) state <= (cnt_next < MIN_LEN_C) ? PAD : FCS;
                     else         state <= DATA;
                  end else begin
                     out_valid <= 1'b0;
                  end
               end
               PAD: begin
                  out_data  <= 8'h00;
                  out_valid <= 1'b1;
                  crc       <= crc32_byte(crc, 8'h00);
                  cnt       <= cnt_inc;
                  if (cnt_inc >= MIN_LEN_C) state <= FCS;
               end
               FCS: begin
                  out_data  <= fcs[{fcs_idx, 3'b000} +: 8];
                  out_valid <= 1'b1;
                  fcs_idx   <= fcs_idx + 2'd1;
                  if (fcs_idx == 2'd3) begin
                     out_last <= 1'b1;
                     state    <= IDLE;
                     crc      <= CRC32_INIT;
                     cnt      <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_crc32_stream_gen.sv
// Scoreboard bench for eth_crc32_stream_gen: a MIN_LEN=60 instance under random traffic
// and a MIN_LEN=0 instance fed the "123456789" check vector.
module tb_eth_crc32_stream_gen;

   localparam int          MIN_LEN_A = 60;
   localparam logic [31:0] POLY      = 32'hEDB8_8320;
   localparam logic [31:0] RESID     = 32'h2144_DF1C;

   typedef logic [7:0] byte_q_t[$];

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0, in_last = 1'b0, in_ready;
   logic [7:0] out_data;
   logic       out_valid, out_last, frame_done;
   logic       out_ready = 1'b1;

   logic [7:0] z_in_data = 8'h00;
   logic       z_in_valid = 1'b0, z_in_last = 1'b0, z_in_ready;
   logic [7:0] z_out_data;
   logic       z_out_valid, z_out_last, z_frame_done;
   logic       z_out_ready = 1'b1;

   eth_crc32_stream_gen #(.MIN_LEN(MIN_LEN_A), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .frame_done(frame_done)
   );

   eth_crc32_stream_gen #(.MIN_LEN(0), .CNT_W(16)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .in_data(z_in_data), .in_valid(z_in_valid), .in_last(z_in_last), .in_ready(z_in_ready),
      .out_data(z_out_data), .out_valid(z_out_valid), .out_last(z_out_last), .out_ready(z_out_ready),
      .frame_done(z_frame_done)
   );

   // ---------------- bookkeeping ----------------
   int         checks = 0;
   int         failures = 0;
   logic [8:0] exp_q[$];      // {last, data}
   int         len_q[$];
   logic [8:0] z_exp_q[$];
   int         frames_expected = 0;
   int         frames_done = 0;
   int         z_done_cnt = 0;
   bit         b2b_seen = 1'b0;
   bit         rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] crc_bit(input logic [31:0] r, input logic b);
      logic fb;
      fb = r[0] ^ b;
      r  = r >> 1;
      if (fb) r = r ^ POLY;
      return r;
   endfunction

   function automatic logic [31:0] crc_bytes(input logic [31:0] r, input byte_q_t msg);
      for (int i = 0; i < msg.size() * 8; i++) r = crc_bit(r, msg[i / 8][i % 8]);
      return r;
   endfunction

   function automatic byte_q_t rand_payload(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic push_expected(input byte_q_t payload);
      byte_q_t     full;
      logic [31:0] f;
      full = payload;
      while (full.size() < MIN_LEN_A) full.push_back(8'h00);
      f = ~crc_bytes(32'hFFFF_FFFF, full);
      foreach (full[i]) exp_q.push_back({1'b0, full[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, f[8*k +: 8]});
      len_q.push_back(full.size() + 4);
      frames_expected++;
   endtask

   // ---------------- drivers ----------------
   task automatic send_frame(input byte_q_t payload, input int gap_pct);
      int n;
      push_expected(payload);
      for (int i = 0; i < payload.size(); i++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         in_data  = payload[i];
         in_valid = 1'b1;
         in_last  = (i == payload.size() - 1);
         n = 0;
         do begin @(negedge clk); n++; end while (!in_ready && n < 2000);
         if (!in_ready) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- monitors / scoreboard ----------------
   int          beat = 0;
   logic [31:0] rx_crc = 32'hFFFF_FFFF;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         exp_q.delete();
         len_q.delete();
         beat   = 0;
         rx_crc = 32'hFFFF_FFFF;
      end else begin
         if (frame_done && in_valid && in_ready) b2b_seen = 1'b1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat: got %h expected none at %0t", out_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e[7:0]);
               check("out_last", out_last, e[8]);
               check("frame_done", frame_done, e[8]);
               for (int j = 0; j < 8; j++) rx_crc = crc_bit(rx_crc, out_data[j]);
               beat++;
               if (e[8]) begin
                  check("beats", beat, len_q.pop_front());
                  check("rx_residual", ~rx_crc, RESID);
                  beat   = 0;
                  rx_crc = 32'hFFFF_FFFF;
                  frames_done++;
               end
            end
         end else if (frame_done) begin
            check("frame_done_no_hs", frame_done, 1'b0);
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n) begin
         if (z_frame_done) z_done_cnt++;
         if (z_out_valid && z_out_ready) begin
            if (z_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL z_unexpected_beat: got %h expected none at %0t", z_out_data, $time);
            end else begin
               e = z_exp_q.pop_front();
               check("z_out_data", z_out_data, e[7:0]);
               check("z_out_last", z_out_last, e[8]);
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_z_out_valid", z_out_valid, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // "123456789" through the MIN_LEN=0 instance
      for (int i = 0; i < 9; i++) z_exp_q.push_back({1'b0, 8'(8'h31 + i)});
      z_exp_q.push_back({1'b0, 8'h26});
      z_exp_q.push_back({1'b0, 8'h39});
      z_exp_q.push_back({1'b0, 8'hF4});
      z_exp_q.push_back({1'b1, 8'hCB});
      for (int i = 0; i < 9; i++) begin
         z_in_data  = 8'(8'h31 + i);
         z_in_valid = 1'b1;
         z_in_last  = (i == 8);
         n = 0;
         do begin @(negedge clk); n++; end while (!z_in_ready && n < 200);
         if (!z_in_ready) begin
            checks++; failures++;
            $display("FAIL z_in_ready_timeout: got 0 expected 1 at %0t", $time);
         end
         @(posedge clk);
         #1;
      end
      z_in_valid = 1'b0;
      z_in_last  = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("z_drain", z_exp_q.size(), 0);
      check("z_frame_done_count", z_done_cnt, 1);

      // pad / no-pad boundaries
      send_frame(rand_payload(14), 0); drain();
      send_frame(rand_payload(60), 0); drain();
      send_frame(rand_payload(61), 0); drain();
      send_frame(rand_payload(1), 0);  drain();

      // backpressure and input bubbles
      rand_ready = 1'b1;
      send_frame(rand_payload(100), 30); drain();
      for (int f = 0; f < 4; f++) begin
         send_frame(rand_payload($urandom_range(1, 90)), $urandom_range(0, 40));
         drain();
      end

      // back-to-back frames with in_valid held high
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      b2b_seen = 1'b0;
      send_frame(rand_payload(20), 0);
      send_frame(rand_payload(70), 0);
      drain();
      check("b2b_accept_in_done_cycle", b2b_seen, 1'b1);

      // reset while padding
      send_frame(rand_payload(14), 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("pre_rst_pad", {out_valid, out_data}, {1'b1, 8'h00});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_in_ready", in_ready, 1'b0);
      frames_expected--;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rand_ready = 1'b1;
      send_frame(rand_payload(30), 20); drain();

      check("frames_done", frames_done, frames_expected);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      checks++; failures++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
